// File: rtl/fetch_sequencer_pkg.sv
// Shared types for the fetch sequencer: FSM states, fault codes and alignment helper.
// Imported by the sequencer RTL and by its testbench.
package fetch_sequencer_pkg;

    typedef enum logic [1:0] {
        S_BOOT  = 2'd0,
        S_REQ   = 2'd1,
        S_DRAIN = 2'd2,
        S_FAULT = 2'd3
    } state_t;

    typedef enum logic [1:0] {
        FAULT_NONE     = 2'b00,
        FAULT_MISALIGN = 2'b01,
        FAULT_TIMEOUT  = 2'b10
    } fault_code_t;

    function automatic logic is_aligned(input logic [1:0] low_bits);
        return low_bits == 2'b00;
    endfunction

endpackage

// File: rtl/fetch_sequencer_if.sv
// Bus bundle between the fetch sequencer and its neighbours: PC register,
// instruction memory, redirect source and decode.
interface fetch_sequencer_if #(
    parameter int unsigned AW = 9,
    parameter int unsigned DW = 32
);
    logic [AW-1:0] pc_addr;
    logic          pc_we;
    logic [AW-1:0] pc_new_addr;
    logic          imem_req;
    logic [AW-1:0] imem_addr;
    logic          imem_ack;
    logic [DW-1:0] imem_rdata;
    logic          redirect_valid;
    logic [AW-1:0] redirect_addr;
    logic          if_valid;
    logic          if_ready;
    logic [DW-1:0] if_instr;
    logic [AW-1:0] if_pc;
    logic          fault;
    logic [1:0]    fault_code;

    modport master (
        input  pc_addr, imem_ack, imem_rdata, redirect_valid, redirect_addr, if_ready,
        output pc_we, pc_new_addr, imem_req, imem_addr, if_valid, if_instr, if_pc,
        fault, fault_code
    );

    modport slave (
        output pc_addr, imem_ack, imem_rdata, redirect_valid, redirect_addr, if_ready,
        input  pc_we, pc_new_addr, imem_req, imem_addr, if_valid, if_instr, if_pc,
        fault, fault_code
    );
endinterface

// File: rtl/fetch_buffer.sv
// One-entry valid/ready holding register between instruction memory and decode.
// Flush wins over load so a redirect discards a same-cycle fetch.
module fetch_buffer #(
    parameter int unsigned AW = 9,
    parameter int unsigned DW = 32
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          flush,
    input  logic          load,
    input  logic [DW-1:0] load_instr,
    input  logic [AW-1:0] load_pc,
    input  logic          ready,
    output logic          valid,
    output logic [DW-1:0] instr,
    output logic [AW-1:0] pc
);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            valid <= 1'b0;
            instr <= '0;
            pc    <= '0;
        end else if (flush) begin
            valid <= 1'b0;
        end else if (load) begin
            // covers consume+refill in the same cycle without a bubble
            valid <= 1'b1;
            instr <= load_instr;
            pc    <= load_pc;
        end else if (ready) begin
            valid <= 1'b0;
        end
    end

endmodule

// File: rtl/fetch_sequencer.sv
// PC sequencing and instruction fetch control: boot, request/ack fetch, drain of
// abandoned requests after a redirect, timeout and misaligned-redirect faults.
module fetch_sequencer
    import fetch_sequencer_pkg::*;
#(
    parameter int unsigned   AW        = 9,
    parameter int unsigned   DW        = 32,
    parameter logic [AW-1:0] RESET_VEC = '0,
    parameter int unsigned   TIMEOUT   = 15
) (
    input  logic              clk,
    input  logic              reset,
    fetch_sequencer_if.master bus
);

    localparam int unsigned CW = $clog2(TIMEOUT + 1);

    state_t        state_q, state_d;
    logic [AW-1:0] drain_addr_q;
    logic [CW-1:0] wait_cnt_q;
    logic          fault_q;
    fault_code_t   fault_code_q;

    logic          buf_valid;
    logic [DW-1:0] buf_instr;
    logic [AW-1:0] buf_pc;

    logic          can_accept;
    logic          redirect;
    logic          redirect_aligned;
    logic          req;
    logic [AW-1:0] fetch_addr;
    logic          acked;
    logic          pending;
    logic          timeout_hit;
    logic          pc_we;
    logic [AW-1:0] pc_new_addr;
    logic          load;
    logic          flush;

    always_comb begin
        can_accept       = !buf_valid || bus.if_ready;
        redirect         = bus.redirect_valid && (state_q == S_REQ || state_q == S_DRAIN);
        redirect_aligned = is_aligned(bus.redirect_addr[1:0]);
        req              = (state_q == S_DRAIN) || (state_q == S_REQ && can_accept);
        fetch_addr       = (state_q == S_DRAIN) ? drain_addr_q : bus.pc_addr;
        acked            = req && bus.imem_ack;
        pending          = req && !bus.imem_ack;
        timeout_hit      = pending && !redirect && (wait_cnt_q == CW'(TIMEOUT - 1));
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_BOOT;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_BOOT: state_d = S_REQ;
            S_REQ, S_DRAIN: begin
                // an unacked request must still be drained from memory after a redirect
                if (redirect) begin
                    if (!redirect_aligned) state_d = S_FAULT;
                    else if (pending)      state_d = S_DRAIN;
                    else                   state_d = S_REQ;
                end else if (timeout_hit) begin
                    state_d = S_FAULT;
                end else if (state_q == S_DRAIN && acked) begin
                    state_d = S_REQ;
                end
            end
            S_FAULT: state_d = S_FAULT;
            default: state_d = S_BOOT;
        endcase
    end

    always_comb begin
        pc_we       = 1'b1;
        pc_new_addr = bus.pc_addr;
        load        = 1'b0;
        flush       = 1'b0;
        case (state_q)
            S_BOOT: pc_new_addr = RESET_VEC;
            S_REQ, S_DRAIN: begin
                if (redirect) begin
                    flush = 1'b1;
                    if (redirect_aligned) pc_new_addr = bus.redirect_addr;
                end else if (timeout_hit) begin
                    flush = 1'b1;
                end else if (state_q == S_REQ && acked) begin
                    pc_we = 1'b0;
                    load  = 1'b1;
                end
            end
            S_FAULT: flush = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            drain_addr_q <= '0;
            wait_cnt_q   <= '0;
            fault_q      <= 1'b0;
            fault_code_q <= FAULT_NONE;
        end else begin
            if (redirect && pending) drain_addr_q <= fetch_addr;

            if (redirect || acked)  wait_cnt_q <= '0;
            else if (pending)       wait_cnt_q <= wait_cnt_q + 1'b1;

            if (state_q != S_FAULT && state_d == S_FAULT) begin
                fault_q      <= 1'b1;
                fault_code_q <= redirect ? FAULT_MISALIGN : FAULT_TIMEOUT;
            end
        end
    end

    fetch_buffer #(
        .AW(AW),
        .DW(DW)
    ) u_buffer (
        .clk       (clk),
        .reset     (reset),
        .flush     (flush),
        .load      (load),
        .load_instr(bus.imem_rdata),
        .load_pc   (fetch_addr),
        .ready     (bus.if_ready),
        .valid     (buf_valid),
        .instr     (buf_instr),
        .pc        (buf_pc)
    );

    assign bus.imem_req    = req;
    assign bus.imem_addr   = fetch_addr;
    assign bus.pc_we       = pc_we;
    assign bus.pc_new_addr = pc_new_addr;
    assign bus.if_valid    = buf_valid;
    assign bus.if_instr    = buf_instr;
    assign bus.if_pc       = buf_pc;
    assign bus.fault       = fault_q;
    assign bus.fault_code  = fault_code_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Self-checking bench for fetch_sequencer: PC register and memory models, a scoreboard
// of expected fetch addresses, a table of redirect/stream vectors and corner sequences.
module tb_fetch_sequencer;
    import fetch_sequencer_pkg::*;

    localparam int unsigned AW = 9;
    localparam int unsigned DW = 32;

    typedef struct {
        logic [8:0]  target;
        int unsigned waits;
        int unsigned count;
        int unsigned gap;
    } vec_t;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    fetch_sequencer_if #(.AW(AW), .DW(DW)) bus ();

    fetch_sequencer #(
        .AW       (AW),
        .DW       (DW),
        .RESET_VEC(9'h000),
        .TIMEOUT  (15)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    int unsigned checks = 0;
    int unsigned errors = 0;
    int unsigned cycle  = 0;
    logic        mon_en    = 1'b0;
    logic        streaming = 1'b0;

    logic [8:0]  exp_q[$];
    int unsigned ctimes[$];

    // PC register model
    logic [8:0] pc_reg = 9'h1A0;
    always @(posedge clk) pc_reg <= bus.pc_we ? bus.pc_new_addr : pc_reg + 9'd4;
    assign bus.pc_addr = pc_reg;

    // Instruction memory model with programmable wait states and stalls
    int unsigned wait_states = 0;
    int unsigned wcnt = 0;
    logic        stall_en  = 1'b0;
    logic        stall_all = 1'b0;
    logic [8:0]  stall_addr = 9'h000;

    function automatic logic [31:0] instr_of(input logic [8:0] a);
        return 32'hA5C0_0000 | {23'h0, a};
    endfunction

    assign bus.imem_ack = bus.imem_req && !stall_all && !(stall_en && bus.imem_addr == stall_addr)
                          && (wcnt >= wait_states);
    assign bus.imem_rdata = instr_of(bus.imem_addr);
    always @(posedge clk) begin
        if (!bus.imem_req || bus.imem_ack) wcnt <= 0;
        else wcnt <= wcnt + 1;
    end
    always @(posedge clk) cycle <= cycle + 1;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, required 0x%0h (cycle %0d)", name, got, exp, cycle);
        end
    endtask

    // Protocol monitor: address/buffer stability and PC control while waiting or streaming
    logic        prev_pend = 1'b0;
    logic        prev_hold = 1'b0;
    logic [8:0]  prev_addr, prev_pc;
    logic [31:0] prev_instr;
    always @(negedge clk) begin
        if (mon_en && reset) begin
            if (prev_pend && bus.imem_req) chk("addr_stable", bus.imem_addr, prev_addr);
            if (prev_hold && bus.if_valid) begin
                chk("buf_instr_stable", bus.if_instr, prev_instr);
                chk("buf_pc_stable", bus.if_pc, prev_pc);
            end
            if (bus.imem_req && !bus.imem_ack && !bus.redirect_valid) begin
                chk("wait_pc_we", bus.pc_we, 1);
                chk("wait_pc_hold", bus.pc_new_addr, bus.pc_addr);
            end
            if (streaming && bus.imem_req && bus.imem_ack && !bus.redirect_valid)
                chk("stream_pc_we", bus.pc_we, 0);
            prev_pend  = bus.imem_req && !bus.imem_ack;
            prev_addr  = bus.imem_addr;
            prev_hold  = bus.if_valid && !bus.if_ready;
            prev_pc    = bus.if_pc;
            prev_instr = bus.if_instr;
        end else begin
            prev_pend = 1'b0;
            prev_hold = 1'b0;
        end
    end

    task automatic apply_reset();
        mon_en = 1'b0;
        reset  = 1'b0;
        exp_q.delete();
        #1;
        chk("rst_if_valid", bus.if_valid, 0);
        chk("rst_if_instr", bus.if_instr, 0);
        chk("rst_if_pc", bus.if_pc, 0);
        chk("rst_fault", bus.fault, 0);
        chk("rst_fault_code", bus.fault_code, 0);
        chk("rst_imem_req", bus.imem_req, 0);
        chk("rst_pc_we", bus.pc_we, 1);
        chk("rst_pc_new", bus.pc_new_addr, 9'h000);
        repeat (2) @(posedge clk);
        #2 reset = 1'b1;
        @(negedge clk);
        chk("boot_imem_req", bus.imem_req, 0);
        chk("boot_pc_we", bus.pc_we, 1);
        chk("boot_pc_new", bus.pc_new_addr, 9'h000);
        mon_en = 1'b1;
    endtask

    task automatic push_seq(input logic [8:0] start, input int unsigned n);
        logic [8:0] a = start;
        for (int unsigned k = 0; k < n; k++) begin
            exp_q.push_back(a);
            a = a + 9'd4;
        end
    endtask

    // Consume n instructions from decode side; gap=0 skips the spacing check
    task automatic stream(input int unsigned n, input int unsigned budget, input int unsigned gap);
        int unsigned got = 0;
        int unsigned spent = 0;
        ctimes.delete();
        @(posedge clk);
        #1 bus.if_ready = 1'b1;
        streaming = 1'b1;
        while (got < n && spent < budget) begin
            @(negedge clk);
            spent++;
            if (bus.if_valid && bus.if_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL sb_unexpected: got pc 0x%0h, required no instruction", bus.if_pc);
                end else begin
                    logic [8:0] e;
                    e = exp_q.pop_front();
                    chk("sb_pc", bus.if_pc, e);
                    chk("sb_instr", bus.if_instr, instr_of(e));
                    ctimes.push_back(cycle);
                    got++;
                end
            end
        end
        if (got < n) begin
            checks++;
            errors++;
            $display("FAIL stream_budget: got %0d instructions, required %0d", got, n);
        end
        if (gap != 0)
            for (int i = 1; i < ctimes.size(); i++) chk("stream_gap", ctimes[i] - ctimes[i-1], gap);
        chk("sb_empty", exp_q.size(), 0);
        @(posedge clk);
        #1 bus.if_ready = 1'b0;
        streaming = 1'b0;
    endtask

    task automatic do_redirect(input logic [8:0] a);
        @(posedge clk);
        #1;
        bus.redirect_addr  = a;
        bus.redirect_valid = 1'b1;
        @(negedge clk);
        chk("redir_pc_we", bus.pc_we, 1);
        chk("redir_pc_new", bus.pc_new_addr, (a[1:0] == 2'b00) ? a : pc_reg);
        @(posedge clk);
        #1 bus.redirect_valid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        vec_t       tbl[4];
        logic [8:0] pc_before;
        int unsigned n;

        tbl[0] = '{target: 9'h100, waits: 0, count: 4, gap: 1};
        tbl[1] = '{target: 9'h020, waits: 2, count: 3, gap: 3};
        tbl[2] = '{target: 9'h1F8, waits: 0, count: 4, gap: 1};
        tbl[3] = '{target: 9'h1F0, waits: 1, count: 3, gap: 2};

        bus.if_ready       = 1'b0;
        bus.redirect_valid = 1'b0;
        bus.redirect_addr  = '0;
        #3;
        apply_reset();

        // Zero-wait streaming from reset
        push_seq(9'h000, 3);
        stream(3, 20, 1);

        // Back-pressure with a full buffer
        repeat (4) begin
            @(negedge clk);
            chk("bp_imem_req", bus.imem_req, 0);
            chk("bp_pc_we", bus.pc_we, 1);
            chk("bp_pc_held", pc_reg, 9'h010);
            chk("bp_if_valid", bus.if_valid, 1);
            chk("bp_if_pc", bus.if_pc, 9'h00C);
            chk("bp_if_instr", bus.if_instr, instr_of(9'h00C));
        end
        push_seq(9'h00C, 3);
        stream(3, 20, 1);

        // Redirect while the fetch of 0x008 is unacked -> drain
        stall_en   = 1'b1;
        stall_addr = 9'h008;
        apply_reset();
        push_seq(9'h000, 2);
        stream(2, 20, 1);
        n = 0;
        while (n < 10 && !(bus.imem_req && bus.imem_addr == 9'h008)) begin
            @(negedge clk);
            n++;
        end
        chk("drain_pre_req", bus.imem_req, 1);
        chk("drain_pre_addr", bus.imem_addr, 9'h008);
        chk("drain_pre_ack", bus.imem_ack, 0);
        push_seq(9'h040, 3);
        do_redirect(9'h040);
        repeat (3) begin
            @(negedge clk);
            chk("drain_req", bus.imem_req, 1);
            chk("drain_addr", bus.imem_addr, 9'h008);
            chk("drain_if_valid", bus.if_valid, 0);
            chk("drain_pc", pc_reg, 9'h040);
        end
        @(posedge clk);
        #1 stall_en = 1'b0;
        @(negedge clk);
        chk("drain_ack", bus.imem_ack, 1);
        chk("drain_ack_pc_we", bus.pc_we, 1);
        stream(3, 20, 1);

        // Table: redirect to target, stream with given wait states, check order and spacing
        for (int i = 0; i < 4; i++) begin
            wait_states = tbl[i].waits;
            repeat (8) @(posedge clk);
            push_seq(tbl[i].target, tbl[i].count);
            do_redirect(tbl[i].target);
            stream(tbl[i].count, tbl[i].count * (tbl[i].waits + 1) + 20, tbl[i].gap);
        end

        // Misaligned redirect -> sticky fault, PC not written
        repeat (8) @(posedge clk);
        pc_before = pc_reg;
        do_redirect(9'h042);
        repeat (3) begin
            @(negedge clk);
            chk("mis_fault", bus.fault, 1);
            chk("mis_code", bus.fault_code, 2'b01);
            chk("mis_imem_req", bus.imem_req, 0);
            chk("mis_if_valid", bus.if_valid, 0);
            chk("mis_pc_held", pc_reg, pc_before);
        end

        // Reset out of fault, then reset again in the middle of a memory wait
        wait_states = 3;
        apply_reset();
        @(negedge clk);
        chk("midwait_req", bus.imem_req, 1);
        chk("midwait_ack", bus.imem_ack, 0);
        #2;
        apply_reset();
        @(negedge clk);
        chk("first_req", bus.imem_req, 1);
        chk("first_addr", bus.imem_addr, 9'h000);
        push_seq(9'h000, 1);
        stream(1, 30, 0);

        // Fetch timeout with imem_ack held low
        wait_states = 0;
        repeat (5) @(posedge clk);
        @(posedge clk);
        #1;
        stall_all    = 1'b1;
        bus.if_ready = 1'b1;
        n = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (bus.fault) break;
            if (bus.imem_req && !bus.imem_ack) n++;
        end
        chk("to_wait_cycles", n, 15);
        chk("to_fault", bus.fault, 1);
        chk("to_code", bus.fault_code, 2'b10);
        chk("to_imem_req", bus.imem_req, 0);
        chk("to_if_valid", bus.if_valid, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
